// File: rtl/data_memory_responder.sv
// Word-organised data memory behind a one-entry store buffer, with sticky error flag and traffic counters.
// Loads are combinational (zero latency) with buffer forwarding; stores never stall and reach the array within 2 cycles.
module data_memory_responder #(
  parameter int DEPTH  = 256,
  parameter int ADDR_W = 16,
  parameter int CNT_W  = 16
) (
  input  logic              Clock,
  input  logic              nReset,
  input  logic [ADDR_W-1:0] Address,
  input  logic              ReadEn,
  output logic [31:0]       ReadData,
  input  logic              WriteEn,
  input  logic [31:0]       WriteData,
  output logic              Error,
  output logic [CNT_W-1:0]  ReadCount,
  output logic [CNT_W-1:0]  WriteCount
);
  localparam int IDX_W = $clog2(DEPTH);

  logic [31:0]      memWords [DEPTH];
  logic             bufValid;
  logic [IDX_W-1:0] bufIndex;
  logic [31:0]      bufData;

  logic [IDX_W-1:0] wordIndex;
  logic             misaligned;
  logic             outOfRange;
  logic             addrOk;
  logic             legalRead;
  logic             legalWrite;
  logic             illegal;
  logic             drainNow;

  assign wordIndex  = Address[IDX_W+1:2];
  assign misaligned = |Address[1:0];
  assign outOfRange = (Address >> (IDX_W + 2)) != '0;
  assign addrOk     = !misaligned && !outOfRange;
  assign legalWrite = WriteEn && addrOk;
  // A read that collides with a write still returns data but is not counted.
  assign legalRead  = ReadEn && !WriteEn && addrOk;
  assign illegal    = ((ReadEn || WriteEn) && !addrOk) || (ReadEn && WriteEn);
  // An illegal write leaves the buffer untouched, so it neither loads nor drains.
  assign drainNow   = bufValid && (legalWrite || !WriteEn);

  always_comb begin
    ReadData = '0;
    if (ReadEn && addrOk) begin
      ReadData = (bufValid && (bufIndex == wordIndex)) ? bufData : memWords[wordIndex];
    end
  end

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      memWords <= '{default: '0};
    end else if (drainNow) begin
      memWords[bufIndex] <= bufData;
    end
  end

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      bufValid <= 1'b0;
      bufIndex <= '0;
      bufData  <= '0;
    end else if (legalWrite) begin
      bufValid <= 1'b1;
      bufIndex <= wordIndex;
      bufData  <= WriteData;
    end else if (!WriteEn) begin
      bufValid <= 1'b0;
    end
  end

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      Error      <= 1'b0;
      ReadCount  <= '0;
      WriteCount <= '0;
    end else begin
      if (illegal) Error <= 1'b1;
      if (legalRead && (ReadCount != '1)) ReadCount <= ReadCount + 1'b1;
      if (legalWrite && (WriteCount != '1)) WriteCount <= WriteCount + 1'b1;
    end
  end

endmodule

// File: tb/tb_data_memory_responder.sv
// Scoreboard bench for data_memory_responder: expected load data queued at drive time, popped at the falling edge.
module tb_data_memory_responder;
  logic        Clock = 1'b0;
  logic        nReset;
  logic [15:0] Address;
  logic        ReadEn;
  logic        WriteEn;
  logic [31:0] WriteData;
  logic [31:0] ReadData;
  logic        Error;
  logic [15:0] ReadCount;
  logic [15:0] WriteCount;
  logic [31:0] ReadData4;
  logic        Error4;
  logic [3:0]  ReadCount4;
  logic [3:0]  WriteCount4;

  int          cmps = 0;
  int          errs = 0;
  logic [31:0] sb[$];
  logic [31:0] expData;

  data_memory_responder #(.DEPTH(256), .ADDR_W(16), .CNT_W(16)) dut (
    .Clock(Clock), .nReset(nReset), .Address(Address), .ReadEn(ReadEn), .ReadData(ReadData),
    .WriteEn(WriteEn), .WriteData(WriteData), .Error(Error), .ReadCount(ReadCount), .WriteCount(WriteCount)
  );

  data_memory_responder #(.DEPTH(256), .ADDR_W(16), .CNT_W(4)) dut4 (
    .Clock(Clock), .nReset(nReset), .Address(Address), .ReadEn(ReadEn), .ReadData(ReadData4),
    .WriteEn(WriteEn), .WriteData(WriteData), .Error(Error4), .ReadCount(ReadCount4), .WriteCount(WriteCount4)
  );

  always #50 Clock = ~Clock;

  task automatic drive(input logic rd, input logic wr, input logic [15:0] a, input logic [31:0] d);
    ReadEn = rd; WriteEn = wr; Address = a; WriteData = d;
  endtask

  task automatic tick;
    @(posedge Clock); #1;
  endtask

  task automatic doReset;
    nReset = 1'b0;
    drive(1'b0, 1'b0, 16'h0, 32'h0);
    #10;
    @(negedge Clock);
    nReset = 1'b1;
    tick();
  endtask

  task automatic test_reset;
    nReset = 1'b0;
    drive(1'b1, 1'b0, 16'h0010, 32'h0);
    #20;
    cmps++; if (ReadData !== 32'h0) begin errs++; $display("FAIL reset_rdata: got %h want 0", ReadData); end
    cmps++; if (Error !== 1'b0) begin errs++; $display("FAIL reset_error: got %b want 0", Error); end
    cmps++; if (ReadCount !== 16'd0 || WriteCount !== 16'd0) begin errs++; $display("FAIL reset_counts: got %0d/%0d want 0/0", ReadCount, WriteCount); end
    cmps++; if (dut.bufValid !== 1'b0) begin errs++; $display("FAIL reset_buf: got %b want 0", dut.bufValid); end
    doReset();
  endtask

  task automatic test_store_load;
    doReset();
    drive(1'b0, 1'b1, 16'h0010, 32'hDEADBEEF); tick();
    drive(1'b0, 1'b0, 16'h0010, 32'h0); tick(); tick();
    drive(1'b1, 1'b0, 16'h0010, 32'h0); sb.push_back(32'hDEADBEEF);
    @(negedge Clock); expData = sb.pop_front();
    cmps++; if (ReadData !== expData) begin errs++; $display("FAIL store_load_rdata: got %h want %h", ReadData, expData); end
    tick(); drive(1'b0, 1'b0, 16'h0, 32'h0);
    cmps++; if (WriteCount !== 16'd1 || ReadCount !== 16'd1) begin errs++; $display("FAIL store_load_counts: got w%0d r%0d want w1 r1", WriteCount, ReadCount); end
    cmps++; if (Error !== 1'b0) begin errs++; $display("FAIL store_load_error: got %b want 0", Error); end
  endtask

  task automatic test_forwarding;
    doReset();
    drive(1'b0, 1'b1, 16'h0020, 32'h12345678); tick();
    drive(1'b1, 1'b0, 16'h0020, 32'h0); sb.push_back(32'h12345678);
    @(negedge Clock); expData = sb.pop_front();
    cmps++; if (ReadData !== expData) begin errs++; $display("FAIL fwd_rdata: got %h want %h", ReadData, expData); end
    cmps++; if (dut.memWords[8] !== 32'h0) begin errs++; $display("FAIL fwd_not_yet: got %h want 0", dut.memWords[8]); end
    tick(); drive(1'b0, 1'b0, 16'h0, 32'h0);
    cmps++; if (dut.memWords[8] !== 32'h12345678) begin errs++; $display("FAIL fwd_drained: got %h want 12345678", dut.memWords[8]); end
  endtask

  task automatic test_back_to_back;
    doReset();
    drive(1'b0, 1'b1, 16'h0000, 32'd1); tick();
    drive(1'b0, 1'b1, 16'h0004, 32'd2); tick();
    drive(1'b0, 1'b1, 16'h0000, 32'd3); tick();
    drive(1'b1, 1'b0, 16'h0000, 32'h0); sb.push_back(32'd3);
    @(negedge Clock); expData = sb.pop_front();
    cmps++; if (ReadData !== expData) begin errs++; $display("FAIL b2b_rd0: got %h want %h", ReadData, expData); end
    tick();
    drive(1'b1, 1'b0, 16'h0004, 32'h0); sb.push_back(32'd2);
    @(negedge Clock); expData = sb.pop_front();
    cmps++; if (ReadData !== expData) begin errs++; $display("FAIL b2b_rd4: got %h want %h", ReadData, expData); end
    tick(); drive(1'b0, 1'b0, 16'h0, 32'h0);
    cmps++; if (WriteCount !== 16'd3) begin errs++; $display("FAIL b2b_wcount: got %0d want 3", WriteCount); end
  endtask

  task automatic test_illegal;
    doReset();
    drive(1'b1, 1'b0, 16'h0013, 32'h0); sb.push_back(32'h0);
    @(negedge Clock); expData = sb.pop_front();
    cmps++; if (ReadData !== expData) begin errs++; $display("FAIL misalign_rdata: got %h want %h", ReadData, expData); end
    tick(); drive(1'b0, 1'b0, 16'h0, 32'h0);
    cmps++; if (Error !== 1'b1) begin errs++; $display("FAIL misalign_error: got %b want 1", Error); end
    cmps++; if (ReadCount !== 16'd0) begin errs++; $display("FAIL misalign_rcount: got %0d want 0", ReadCount); end
    tick();
    cmps++; if (Error !== 1'b1) begin errs++; $display("FAIL error_sticky: got %b want 1", Error); end

    doReset();
    drive(1'b0, 1'b1, 16'h0400, 32'hFFFFFFFF); tick();
    drive(1'b0, 1'b0, 16'h0, 32'h0);
    cmps++; if (Error !== 1'b1) begin errs++; $display("FAIL oor_error: got %b want 1", Error); end
    cmps++; if (WriteCount !== 16'd0 || dut.bufValid !== 1'b0) begin errs++; $display("FAIL oor_dropped: got w%0d buf%b want w0 buf0", WriteCount, dut.bufValid); end
    tick();
    cmps++; if (dut.memWords[0] !== 32'h0) begin errs++; $display("FAIL oor_word0: got %h want 0", dut.memWords[0]); end

    doReset();
    drive(1'b0, 1'b0, 16'hFFFF, 32'h0); tick();
    cmps++; if (Error !== 1'b0) begin errs++; $display("FAIL idle_garbage_error: got %b want 0", Error); end
  endtask

  task automatic test_simultaneous;
    doReset();
    drive(1'b0, 1'b1, 16'h0030, 32'hAAAA0000); tick();
    drive(1'b0, 1'b0, 16'h0, 32'h0); tick();
    drive(1'b1, 1'b1, 16'h0030, 32'h5555FFFF); sb.push_back(32'hAAAA0000);
    @(negedge Clock); expData = sb.pop_front();
    cmps++; if (ReadData !== expData) begin errs++; $display("FAIL simul_rdata: got %h want %h", ReadData, expData); end
    tick(); drive(1'b0, 1'b0, 16'h0, 32'h0);
    cmps++; if (Error !== 1'b1) begin errs++; $display("FAIL simul_error: got %b want 1", Error); end
    cmps++; if (ReadCount !== 16'd0 || WriteCount !== 16'd2) begin errs++; $display("FAIL simul_counts: got r%0d w%0d want r0 w2", ReadCount, WriteCount); end
    tick();
    drive(1'b1, 1'b0, 16'h0030, 32'h0); sb.push_back(32'h5555FFFF);
    @(negedge Clock); expData = sb.pop_front();
    cmps++; if (ReadData !== expData) begin errs++; $display("FAIL simul_later_rd: got %h want %h", ReadData, expData); end
    tick(); drive(1'b0, 1'b0, 16'h0, 32'h0);
  endtask

  task automatic test_reset_mid;
    doReset();
    drive(1'b0, 1'b1, 16'h0040, 32'hCAFEF00D); tick();
    cmps++; if (WriteCount !== 16'd1) begin errs++; $display("FAIL mid_pre_wcount: got %0d want 1", WriteCount); end
    #29;
    drive(1'b1, 1'b0, 16'h0040, 32'h0);
    nReset = 1'b0;
    #1;
    cmps++; if (ReadData !== 32'h0 || Error !== 1'b0) begin errs++; $display("FAIL mid_outputs: got %h err %b want 0 0", ReadData, Error); end
    cmps++; if (WriteCount !== 16'd0 || ReadCount !== 16'd0) begin errs++; $display("FAIL mid_counts: got w%0d r%0d want 0 0", WriteCount, ReadCount); end
    @(negedge Clock); nReset = 1'b1;
    drive(1'b0, 1'b0, 16'h0, 32'h0);
    tick(); tick();
    drive(1'b1, 1'b0, 16'h0040, 32'h0); sb.push_back(32'h0);
    @(negedge Clock); expData = sb.pop_front();
    cmps++; if (ReadData !== expData) begin errs++; $display("FAIL mid_discarded: got %h want %h", ReadData, expData); end
    cmps++; if (dut.memWords[16] !== 32'h0) begin errs++; $display("FAIL mid_word16: got %h want 0", dut.memWords[16]); end
    tick(); drive(1'b0, 1'b0, 16'h0, 32'h0);
  endtask

  task automatic test_saturation;
    doReset();
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, 1'b0, 16'h0008, 32'h0); sb.push_back(32'h0);
      @(negedge Clock); expData = sb.pop_front();
      cmps++; if (ReadData !== expData) begin errs++; $display("FAIL sat_rdata%0d: got %h want %h", i, ReadData, expData); end
      tick();
    end
    drive(1'b0, 1'b0, 16'h0, 32'h0);
    cmps++; if (ReadCount4 !== 4'd15) begin errs++; $display("FAIL sat_rcount4: got %0d want 15", ReadCount4); end
    cmps++; if (ReadCount !== 16'd20) begin errs++; $display("FAIL sat_rcount16: got %0d want 20", ReadCount); end
    cmps++; if (WriteCount4 !== 4'd0 || Error4 !== 1'b0) begin errs++; $display("FAIL sat_others: got w%0d err %b want 0 0", WriteCount4, Error4); end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    nReset = 1'b0;
    drive(1'b0, 1'b0, 16'h0, 32'h0);
    test_reset();
    test_store_load();
    test_forwarding();
    test_back_to_back();
    test_illegal();
    test_simultaneous();
    test_reset_mid();
    test_saturation();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmps, errs);
    $finish;
  end

endmodule

// File: doc/data_memory_responder.md
Name: data_memory_responder

Overview:
- Word-organised data memory that answers the processor's load/store port (MemAddr, MemRead, MemWrite, MemData, WriteData).
- Stores are committed through a one-entry store buffer; loads forward from that buffer.
- Flags illegal accesses and counts traffic so benches can check memory-side activity independently of the register-file comparison.
- Instantiated beside PROCESSOR in system benches and in the top-level wrapper.

Parameters:
- DEPTH, 256, number of 32-bit words; power of two, 4 to 16384.
- ADDR_W, 16, byte-address width of Address.
- CNT_W, 16, width of the access counters.

Ports:
- Clock  input  1  system clock, rising-edge active.
- nReset  input  1  asynchronous active-low reset.
- Address  input  ADDR_W  byte address from the processor.
- ReadEn  input  1  load request this cycle.
- ReadData  output  32  load data.
- WriteEn  input  1  store request this cycle.
- WriteData  input  32  store data.
- Error  output  1  sticky illegal-access flag.
- ReadCount  output  CNT_W  accepted loads since reset.
- WriteCount  output  CNT_W  accepted stores since reset.

Behaviour:
- Clock and reset: one clock, Clock. Reset nReset is asynchronous and active-low.
- Reset values:
  - All array words = 0.
  - Store buffer invalid.
  - Error = 0.
  - ReadCount = 0 and WriteCount = 0.
  - ReadData = 0.
- Reset mid-operation discards a pending buffered store; that write is never committed.
- Word index = Address[log2(DEPTH)+1:2].
- Out-of-range address: Address[ADDR_W-1:log2(DEPTH)+2] non-zero is out of range.
- Misaligned address: Address[1:0] != 0.
- Store buffer, one entry holding {valid, index, data}:
  - WriteEn=1 and access legal, at the rising edge: the entry loads {1, index, WriteData}. If the entry was already valid, its old contents are written into the array in the same edge.
  - WriteEn=0 and entry valid, at the rising edge: the entry is drained to the array and valid clears.
  - Result: every store reaches the array within 2 cycles, and back-to-back stores never stall.
- Loads (combinational read, zero latency):
  - ReadEn=1 and legal: if the buffer is valid and its index matches, ReadData = buffer data (forwarding). Otherwise ReadData = array[index].
  - ReadEn=0 or illegal: ReadData = 0.
- Simultaneous ReadEn=1 and WriteEn=1:
  - Treated as illegal; Error sets.
  - The write is still performed, if its address is legal.
  - ReadData returns the value visible before this write (buffer forwarding still applies).
  - ReadCount does not increment.
- Error:
  - Sets at the rising edge after any cycle with a misaligned access, an out-of-range access, or simultaneous read/write.
  - Stays set until nReset.
  - Illegal writes are dropped and do not change the buffer.
- Counters:
  - ReadCount increments on each cycle with a legal read only.
  - WriteCount increments on each cycle with a legal write.
  - Both saturate at all-ones and do not wrap.
- Idle (ReadEn=0, WriteEn=0): no state change apart from buffer drain.
- Any value on Address is permitted when both enables are 0; no Error, no effect.

Test Plan:
- Reset → store → load:
  - Release reset, then write 0xDEADBEEF to 0x0010 and deassert WriteEn.
  - Two cycles later, read 0x0010 → ReadData = 0xDEADBEEF.
  - WriteCount = 1, ReadCount = 1, Error = 0.
- Forwarding:
  - Write 0x12345678 to 0x0020, then read 0x0020 the next cycle while the entry is still buffered → ReadData = 0x12345678 that same cycle.
  - Array word 8 holds 0x12345678 one cycle later.
- Back-to-back stores:
  - Write 1, 2, 3 to 0x0000, 0x0004, 0x0000 on consecutive cycles, then read 0x0000 and 0x0004 → 3 and 2.
  - WriteCount = 3.
- Illegal accesses:
  - Read 0x0013 (misaligned) → ReadData = 0, Error = 1 next edge, ReadCount unchanged.
  - After reset, write to 0x0400 with DEPTH=256 (out of range) → Error = 1 next edge; array word 0 still 0.
- Simultaneous read/write:
  - Preload 0x0030 with 0xAAAA0000. ReadEn=WriteEn=1 at 0x0030 with WriteData 0x5555FFFF → ReadData = 0xAAAA0000 that cycle, Error = 1 next edge.
  - A later read of 0x0030 returns 0x5555FFFF.
- Reset mid-operation and saturation:
  - Write 0xCAFEF00D to 0x0040, then assert nReset low 30 ns after the edge (asynchronously) → all outputs 0 immediately.
  - After release, read 0x0040 → 0.
  - With CNT_W=4, 20 legal reads → ReadCount = 15.
